// File: rtl/dcache_pkg.sv
// Shared types and constants for the set-associative data cache.
// Optional perf counters are enabled with DCACHE_PERF_EN.
package dcache_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WB,
    S_RF
  } state_e;

  localparam int          A_WIDTH_DEF = 32;
  localparam int          IDX_W_DEF   = 7;
  localparam int          WAYS_DEF    = 2;
  localparam int          LW_LOG2_DEF = 2;
  localparam logic [15:0] UNC_HI_DEF  = 16'hbfaf;
  localparam logic [15:0] UNC_REMAP   = 16'h1faf;

  function automatic int tag_width(int aw, int iw, int lw);
    return aw - iw - lw - 2;
  endfunction

  localparam int TAG_W_DEF =
    tag_width(A_WIDTH_DEF, IDX_W_DEF, LW_LOG2_DEF);

endpackage

// File: rtl/dcache_way.sv
// One cache way: valid/dirty/tag per set and a word array
// with a byte-merging write port.
module dcache_way #(
  parameter int IDX_W   = 7,
  parameter int LW_LOG2 = 2,
  parameter int TAG_W   = 21
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IDX_W-1:0]   idx_i,
  input  logic [LW_LOG2-1:0] word_i,
  output logic               valid_o,
  output logic               dirty_o,
  output logic [TAG_W-1:0]   tag_o,
  output logic [31:0]        rdata_o,
  input  logic               wr_en_i,
  input  logic [3:0]         wr_be_i,
  input  logic [31:0]        wr_data_i,
  input  logic               mark_dirty_i,
  input  logic               fill_i,
  input  logic [TAG_W-1:0]   fill_tag_i
);

  localparam int SETS = 1 << IDX_W;
  localparam int WRDS = SETS << LW_LOG2;

  logic [SETS-1:0]  valid_q;
  logic [SETS-1:0]  dirty_q;
  logic [TAG_W-1:0] tag_q [SETS];
  logic [31:0]      data_q [WRDS];

  logic [IDX_W+LW_LOG2-1:0] waddr;
  assign waddr = {idx_i, word_i};

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign rdata_o = data_q[waddr];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (mark_dirty_i) dirty_q[idx_i] <= 1'b1;
      if (fill_i) begin
        valid_q[idx_i] <= 1'b1;
        dirty_q[idx_i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_i) tag_q[idx_i] <= fill_tag_i;
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_en_i && wr_be_i[b])
        data_q[waddr][8*b +: 8] <= wr_data_i[8*b +: 8];
    end
  end

endmodule

// File: rtl/d_cache_assoc.sv
// 1/2-way set-associative write-back data cache with uncached window.
// Define DCACHE_PERF_EN to add perf_hit/perf_miss counters.
module d_cache_assoc
  import dcache_pkg::*;
#(
  parameter int          A_WIDTH = A_WIDTH_DEF,
  parameter int          IDX_W   = IDX_W_DEF,
  parameter int          WAYS    = WAYS_DEF,
  parameter int          LW_LOG2 = LW_LOG2_DEF,
  parameter logic [15:0] UNC_HI  = UNC_HI_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [A_WIDTH-1:0] p_a,
  input  logic [31:0]        p_dout,
  output logic [31:0]        p_din,
  input  logic               p_strobe,
  input  logic [3:0]         p_wen,
  input  logic [1:0]         p_size,
  input  logic               p_rw,
  output logic               p_ready,
  output logic [A_WIDTH-1:0] m_a,
  input  logic [31:0]        m_dout,
  output logic [31:0]        m_din,
  output logic               m_strobe,
  output logic [3:0]         m_wen,
  output logic [1:0]         m_size,
  output logic               m_rw,
  input  logic               m_ready
`ifdef DCACHE_PERF_EN
  ,
  output logic [31:0]        perf_hit,
  output logic [31:0]        perf_miss
`endif
);

  localparam int TAG_W = tag_width(A_WIDTH, IDX_W, LW_LOG2);
  localparam int SETS  = 1 << IDX_W;

  state_e             state_q;
  logic [LW_LOG2-1:0] cnt_q;
  logic               victim_q;
  logic [SETS-1:0]    lru_q;
  logic [IDX_W-1:0]   idx_q;
  logic [TAG_W-1:0]   mtag_q;

  logic [LW_LOG2-1:0] p_word;
  logic [IDX_W-1:0]   p_idx;
  logic [TAG_W-1:0]   p_tag;
  assign p_word = p_a[LW_LOG2+1:2];
  assign p_idx  = p_a[LW_LOG2+2 +: IDX_W];
  assign p_tag  = p_a[A_WIDTH-1 -: TAG_W];

  logic unc, idle, last;
  assign unc  = p_a[31:16] == UNC_HI;
  assign idle = state_q == S_IDLE;
  assign last = &cnt_q;

  logic [WAYS-1:0]  w_valid, w_dirty, hit_w;
  logic [TAG_W-1:0] w_tag   [WAYS];
  logic [31:0]      w_rdata [WAYS];

  logic hit, hit_way, vict_sel, vdirty;
  logic creq, hit_ok, miss, rf_xfer;
  assign hit     = |hit_w;
  assign creq    = idle && p_strobe && !unc;
  assign hit_ok  = creq && hit;
  assign miss    = creq && !hit;
  assign rf_xfer = (state_q == S_RF) && m_ready;
  assign vdirty  = w_dirty[vict_sel];

  logic [IDX_W-1:0]   way_idx;
  logic [LW_LOG2-1:0] way_word;
  assign way_idx  = idle ? p_idx : idx_q;
  assign way_word = idle ? p_word : cnt_q;

  if (WAYS == 2) begin : g_two
    assign hit_way  = hit_w[1];
    assign vict_sel = !w_valid[0] ? 1'b0 :
                      !w_valid[1] ? 1'b1 : lru_q[p_idx];
  end else begin : g_one
    assign hit_way  = 1'b0;
    assign vict_sel = 1'b0;
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    localparam logic WID = 1'(w);
    logic hwr, mine;
    assign hit_w[w] = w_valid[w] && (w_tag[w] == p_tag);
    assign hwr      = hit_ok && p_rw && hit_w[w];
    assign mine     = victim_q == WID;

    dcache_way #(
      .IDX_W  (IDX_W),
      .LW_LOG2(LW_LOG2),
      .TAG_W  (TAG_W)
    ) u_way (
      .clk         (clk),
      .rst         (rst),
      .idx_i       (way_idx),
      .word_i      (way_word),
      .valid_o     (w_valid[w]),
      .dirty_o     (w_dirty[w]),
      .tag_o       (w_tag[w]),
      .rdata_o     (w_rdata[w]),
      .wr_en_i     (hwr || (rf_xfer && mine)),
      .wr_be_i     (idle ? p_wen : 4'hf),
      .wr_data_i   (idle ? p_dout : m_dout),
      .mark_dirty_i(hwr),
      .fill_i      (rf_xfer && last && mine),
      .fill_tag_i  (mtag_q)
    );
  end

  always_comb begin
    p_din    = w_rdata[hit_way];
    p_ready  = 1'b0;
    m_a      = '0;
    m_din    = '0;
    m_strobe = 1'b0;
    m_wen    = 4'h0;
    m_size   = 2'b00;
    m_rw     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (unc) begin
          m_a      = {UNC_REMAP, p_a[15:0]};
          m_din    = p_dout;
          m_strobe = p_strobe;
          m_wen    = p_wen;
          m_size   = p_size;
          m_rw     = p_rw;
          p_din    = m_dout;
          p_ready  = m_ready;
        end else begin
          p_ready  = hit_ok;
        end
      end
      S_WB: begin
        m_strobe = 1'b1;
        m_rw     = 1'b1;
        m_wen    = 4'hf;
        m_size   = 2'b10;
        m_a      = {w_tag[victim_q], idx_q, cnt_q, 2'b00};
        m_din    = w_rdata[victim_q];
      end
      S_RF: begin
        m_strobe = 1'b1;
        m_size   = 2'b10;
        m_a      = {mtag_q, idx_q, cnt_q, 2'b00};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      victim_q <= 1'b0;
      lru_q    <= '0;
      idx_q    <= '0;
      mtag_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (hit_ok && WAYS == 2) lru_q[p_idx] <= ~hit_way;
          if (miss) begin
            victim_q <= vict_sel;
            idx_q    <= p_idx;
            mtag_q   <= p_tag;
            cnt_q    <= '0;
            state_q  <= vdirty ? S_WB : S_RF;
          end
        end
        S_WB: begin
          if (m_ready) begin
            cnt_q <= cnt_q + 1'b1;
            if (last) state_q <= S_RF;
          end
        end
        S_RF: begin
          if (m_ready) begin
            cnt_q <= cnt_q + 1'b1;
            if (last) begin
              state_q <= S_IDLE;
              if (WAYS == 2) lru_q[idx_q] <= ~victim_q;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef DCACHE_PERF_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_ok) hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss)   miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end
  assign perf_hit  = hit_cnt_q;
  assign perf_miss = miss_cnt_q;
`endif

endmodule

// File: doc/d_cache_assoc.md
Name: d_cache_assoc

Overview:
Parametrised successor to the direct-mapped word-line data cache. Set-associative (1 or 2 ways), multi-word lines with burst refill and write-back, per-set LRU replacement, and the same uncached pass-through window. Sits between the MEM stage (p_* side) and the single-word memory bridge (m_* side); both port sets keep the existing data cache's names and handshake.

Parameters:
A_WIDTH, 32, address width
IDX_W, 7, set index bits (2^IDX_W sets)
WAYS, 2, associativity; legal values 1 or 2
LW_LOG2, 2, log2 words per line (line = 2^LW_LOG2 x 32 bit)
UNC_HI, 16'hbfaf, p_a[31:16] value selecting the uncached window

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
p_a  in  A_WIDTH  CPU byte address
p_dout  in  32  CPU store data
p_din  out  32  load data to CPU
p_strobe  in  1  access request; held with stable p_a/p_rw/p_wen/p_dout until p_ready
p_wen  in  4  byte enables; bit3 = [31:24]
p_size  in  2  access size (passed through on uncached)
p_rw  in  1  0 read, 1 write
p_ready  out  1  access complete this cycle
m_a  out  A_WIDTH  memory word address
m_dout  in  32  memory read data
m_din  out  32  memory write data
m_strobe  out  1  memory request
m_wen  out  4  memory byte enables
m_size  out  2  memory size
m_rw  out  1  0 read, 1 write
m_ready  in  1  memory word done

Behaviour:
- Address split: word = p_a[LW_LOG2+1:2], index = next IDX_W bits, tag = remaining upper bits.
- States: IDLE, WB (write back victim), RF (refill). Reset: state IDLE, all valid/dirty/LRU cleared, m_strobe=0, p_ready=0, word counter 0.
- Uncached (p_a[31:16]==UNC_HI) in IDLE: combinational pass-through; m_a={16'h1faf,p_a[15:0]}; m_din/m_wen/m_size/m_rw/m_strobe from p_*; p_din=m_dout; p_ready=m_ready. Cache arrays untouched.
- Hit (p_strobe, valid, tag match in any way, IDLE): p_ready=1 same cycle, p_din = matching way word. A write merges only bytes with p_wen set at the clock edge and sets dirty. LRU bit points at the other way.
- Miss in IDLE: victim = lowest-numbered invalid way, else the LRU way (WAYS=1: way 0). Dirty victim -> WB; otherwise -> RF. p_ready=0 throughout.
- WB: m_strobe=1, m_rw=1, m_wen=4'hf, m_size=2'b10, m_a={victim tag,index,cnt,2'b00}, m_din=victim word cnt. cnt increments on m_ready; on m_ready at last word, cnt=0 -> RF.
- RF: m_strobe=1, m_rw=0, m_a={tag,index,cnt,2'b00}. Each m_ready writes m_dout into victim word cnt. At the last word: tag installed, valid=1, dirty=0 -> IDLE. The next cycle is a hit (miss latency = words transferred + 1).
- m_strobe is 0 in IDLE unless uncached. No word is skipped or repeated. m_ready outside WB/RF/uncached is ignored.
- p_strobe dropping mid-miss: the current line transfer still completes; no p_ready is issued.
- Reset mid-WB/RF: abort immediately; m_strobe=0 next cycle; the partial line is never valid.

Optional Feature:
DCACHE_PERF_EN: adds outputs perf_hit[31:0] and perf_miss[31:0]. perf_hit counts cycles with p_ready on cached accesses. perf_miss counts IDLE->WB/RF transitions. Both wrap at 2^32 and clear on rst. Without the macro: ports absent, no counter logic.

Decomposition:
- Package dcache_pkg: state enum (IDLE/WB/RF), field-width localparams derived from the parameters, UNC_HI, and the 16'h1faf remap constant.
- Sub-module dcache_way: one way's valid/dirty/tag/data arrays with a byte-merge write port; instantiated WAYS times.

Test Plan:
- Cold read p_a=0x00001008, memory words 0x11,0x22,0x33,0x44 at 0x1000..0x100C -> four m_rw=0 reads in order 0x1000..0x100C; p_ready next cycle with p_din=0x33.
- Write hit to 0x00001004 with p_wen=4'b0100, p_dout=0x00AB0000 -> p_ready same cycle; later read returns 0x22 with byte2 replaced by 0xAB; no memory traffic.
- Three same-index tags A, B, C (WAYS=2), A dirty -> C evicts A (LRU); four m_rw=1 writes of A's line precede C's refill.
- After A, B filled, touch A then miss on C -> B is evicted, not A.
- Uncached read p_a=0xbfaf0010 -> m_a=0x1faf0010; p_ready tracks m_ready; cache state unchanged.
- Assert rst during the 2nd refill word -> m_strobe=0 next cycle; re-reading that address misses.
